img_scale_stream: RTL and testbench

- Parametrised successor to the fixed-size LCD scaling controller.
- Reads a SRC_W x SRC_H frame from single-port BRAM (1-cycle read latency) and streams nearest-neighbour-scaled pixels to the LCD writer.
- Independent X/Y scale modes, a ready/valid output with backpressure, frame/line markers and a sticky done flag.
- Sits between bufferram and the LCD interface logic.

---
 rtl/scale_pkg.sv | 26 ++
 rtl/img_scale_stream_if.sv | 15 +
 rtl/pix_skid_buf.sv | 56 +++++
 rtl/img_scale_stream.sv | 147 ++++++++++++++
 tb/tb_img_scale_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/scale_pkg.sv
// Shared definitions for the nearest-neighbour image scaler:
// scale-mode encoding, controller states and output-size helper.
package scale_pkg;

  localparam logic [1:0] SCALE_X1   = 2'd0;
  localparam logic [1:0] SCALE_X2   = 2'd1;
  localparam logic [1:0] SCALE_X4   = 2'd2;
  localparam logic [1:0] SCALE_HALF = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output extent of one axis for a given scale mode (halving floors).
  function automatic int unsigned out_dim(input int unsigned src_dim, input logic [1:0] mode);
    case (mode)
      SCALE_X2:   return src_dim << 1;
      SCALE_X4:   return src_dim << 2;
      SCALE_HALF: return src_dim >> 1;
      default:    return src_dim;
    endcase
  endfunction

endpackage

// File: rtl/img_scale_stream_if.sv
// Pixel stream towards the LCD writer: ready/valid with frame/line markers.
interface img_scale_stream_if #(
  parameter int PIX_W = 16
);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_sof;
  logic             pix_eol;

  modport master (output pix_data, output pix_valid, output pix_sof, output pix_eol,
                  input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_sof, input pix_eol,
                  output pix_ready);
endinterface

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO holding returned pixels with their tags; entry0 is always the head,
// so the head only changes on a pop and stays stable while the sink stalls.
module pix_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);

  logic [1:0]   occ_q;
  logic [W-1:0] entry0_q;
  logic [W-1:0] entry1_q;
  logic         pop;

  assign pop     = pop_i && (occ_q != 2'd0);
  assign valid_o = (occ_q != 2'd0);
  assign head_o  = entry0_q;
  assign occ_o   = occ_q;

  // The issuer's credit check guarantees push never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          if (occ_q == 2'd0) entry0_q <= push_data_i;
          else               entry1_q <= push_data_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          entry0_q <= entry1_q;
          occ_q    <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            entry0_q <= push_data_i;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/img_scale_stream.sv
// Streams a nearest-neighbour scaled copy of a SRC_W x SRC_H BRAM frame to the LCD
// writer, one BRAM read per output pixel, throttled by a two-credit skid buffer.
module img_scale_stream
  import scale_pkg::*;
#(
  parameter int PIX_W  = 16,
  parameter int SRC_W  = 128,
  parameter int SRC_H  = 128,
  parameter int ADDR_W = $clog2(SRC_W*SRC_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         scale_x,
  input  logic [1:0]         scale_y,
  output logic               bram_en,
  output logic [ADDR_W-1:0]  bram_addr,
  input  logic [PIX_W-1:0]   bram_data,
  img_scale_stream_if.master pix,
  output logic               busy,
  output logic               frame_done
);

  localparam int MAX_D = (SRC_W > SRC_H) ? SRC_W : SRC_H;
  localparam int CW    = $clog2(4*MAX_D + 1);
  localparam int BW    = PIX_W + 2;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

  state_t            state_q;
  logic [1:0]        mode_x_q, mode_y_q;
  logic [CW-1:0]     ox_q, oy_q, oy_inc, out_w, out_h;
  logic [ADDR_W-1:0] row_base_q, row_step;
  logic [CW:0]       sx;
  logic              in_flight_q, fl_sof_q, fl_eol_q, busy_q, frame_done_q;
  logic              issue, pop, last_col, last_row, iss_sof;
  logic [2:0]        credit_use;
  logic [1:0]        occ;
  logic              head_valid;
  logic [BW-1:0]     head;

  assign out_w    = CW'(out_dim(SRC_W, mode_x_q));
  assign out_h    = CW'(out_dim(SRC_H, mode_y_q));
  assign last_col = (ox_q == out_w - CW'(1));
  assign last_row = (oy_q == out_h - CW'(1));
  assign iss_sof  = (ox_q == '0) && (oy_q == '0);
  assign oy_inc   = oy_q + CW'(1);

  always_comb begin
    case (mode_x_q)
      SCALE_X2:   sx = {1'b0, ox_q} >> 1;
      SCALE_X4:   sx = {1'b0, ox_q} >> 2;
      SCALE_HALF: sx = {1'b0, ox_q} << 1;
      default:    sx = {1'b0, ox_q};
    endcase
  end

  // Row base advances only when the new output line maps to a new source row.
  always_comb begin
    row_step = '0;
    case (mode_y_q)
      SCALE_X1: row_step = ROW_STEP;
      SCALE_X2: if (oy_inc[0] == 1'b0) row_step = ROW_STEP;
      SCALE_X4: if (oy_inc[1:0] == 2'b00) row_step = ROW_STEP;
      default:  row_step = ROW_STEP << 1;
    endcase
  end

  assign pop        = head_valid && pix.pix_ready;
  assign credit_use = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};
  assign issue      = (state_q == RUN) && (credit_use < 3'd2);
  assign bram_en    = issue;
  assign bram_addr  = row_base_q + ADDR_W'(sx);

  pix_skid_buf #(.W(BW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_flight_q),
    .push_data_i ({fl_sof_q, fl_eol_q, bram_data}),
    .pop_i       (pop),
    .valid_o     (head_valid),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign pix.pix_data  = head[PIX_W-1:0];
  assign pix.pix_valid = head_valid;
  assign pix.pix_sof   = head_valid && head[PIX_W+1];
  assign pix.pix_eol   = head_valid && head[PIX_W];
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_x_q     <= SCALE_X1;
      mode_y_q     <= SCALE_X1;
      ox_q         <= '0;
      oy_q         <= '0;
      row_base_q   <= '0;
      in_flight_q  <= 1'b0;
      fl_sof_q     <= 1'b0;
      fl_eol_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      in_flight_q <= issue;
      fl_sof_q    <= issue && iss_sof;
      fl_eol_q    <= issue && last_col;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_x_q     <= scale_x;
            mode_y_q     <= scale_y;
            ox_q         <= '0;
            oy_q         <= '0;
            row_base_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_col) begin
              ox_q       <= '0;
              oy_q       <= oy_inc;
              row_base_q <= row_base_q + row_step;
              if (last_row) state_q <= DRAIN;
            end else begin
              ox_q <= ox_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          // Final pixel: nothing in flight and it is the only buffered entry.
          if (!in_flight_q && (occ == 2'd1) && pop) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_scale_stream.sv
// Directed bench for img_scale_stream on a 4x4 source: a reference model fills
// address and pixel queues at start, which are drained as reads and acceptances occur.
module tb_img_scale_stream;
  import scale_pkg::*;

  localparam int PIX_W  = 16;
  localparam int SRC_W  = 4;
  localparam int SRC_H  = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        scale_x, scale_y;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_data;
  logic              busy, frame_done;

  img_scale_stream_if #(.PIX_W(PIX_W)) pix_bus ();

  img_scale_stream #(
    .PIX_W(PIX_W), .SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .scale_x    (scale_x),
    .scale_y    (scale_y),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .pix        (pix_bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
  } pix_t;

  logic [PIX_W-1:0] mem [SRC_W*SRC_H];
  pix_t pix_q [$];
  int   addr_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_en) bram_data <= mem[bram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_dim(input int src, input logic [1:0] m);
    if (m == 2'd1) return src * 2;
    if (m == 2'd2) return src * 4;
    if (m == 2'd3) return src / 2;
    return src;
  endfunction

  function automatic int tb_src(input int o, input logic [1:0] m);
    if (m == 2'd1) return o / 2;
    if (m == 2'd2) return o / 4;
    if (m == 2'd3) return o * 2;
    return o;
  endfunction

  task automatic push_expected(input logic [1:0] mx, input logic [1:0] my);
    int ow, oh, a;
    pix_t p;
    ow = tb_dim(SRC_W, mx);
    oh = tb_dim(SRC_H, my);
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        a = tb_src(oy, my) * SRC_W + tb_src(ox, mx);
        addr_q.push_back(a);
        p.data = mem[a];
        p.sof  = (ox == 0) && (oy == 0);
        p.eol  = (ox == ow - 1);
        pix_q.push_back(p);
      end
    end
  endtask

  // pat: 0 ready high, 1 toggling, 2 random stalls. abort_after>0 returns after that many
  // acceptances. restart_at>=0 pulses start at that cycle; -2 pulses it with the final acceptance.
  task automatic run_frame(input logic [1:0] mx, input logic [1:0] my, input int pat,
                           input int abort_after, input int restart_at);
    int   outstanding = 0;
    int   accepted    = 0;
    int   first_valid = -1;
    bit   held = 1'b0;
    bit   fin  = 1'b0;
    bit   acc;
    pix_t held_p, exp_p;
    @(negedge clk);
    start = 1'b1;
    scale_x = mx;
    scale_y = my;
    pix_bus.pix_ready = 1'b1;
    push_expected(mx, my);
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      case (pat)
        1:       pix_bus.pix_ready = (c % 2 == 0);
        2:       pix_bus.pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_bus.pix_ready = 1'b1;
      endcase
      #1;
      if (c == restart_at) begin
        start = 1'b1;
        scale_x = SCALE_X2;
        scale_y = SCALE_X2;
      end
      if (c == 0) begin
        check("bram_en_first", 32'(bram_en), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        check("done_clear", 32'(frame_done), 32'd0);
      end
      if (pix_bus.pix_valid && first_valid < 0) begin
        first_valid = c;
        if (pat == 0) check("first_valid_lat", 32'(c), 32'd2);
      end
      if (held) begin
        check("stall_valid", 32'(pix_bus.pix_valid), 32'd1);
        check("stall_data", 32'(pix_bus.pix_data), 32'(held_p.data));
        check("stall_tags", 32'({pix_bus.pix_sof, pix_bus.pix_eol}), 32'({held_p.sof, held_p.eol}));
      end
      acc = pix_bus.pix_valid && pix_bus.pix_ready;
      if (bram_en) begin
        check("credit", 32'(outstanding - int'(acc) < 2), 32'd1);
        if (addr_q.size() == 0) check("extra_read", 32'd1, 32'd0);
        else check("addr", 32'(bram_addr), 32'(addr_q.pop_front()));
      end
      if (acc) begin
        if (pix_q.size() == 0) begin
          check("extra_pixel", 32'd1, 32'd0);
        end else begin
          exp_p = pix_q.pop_front();
          check("pix_data", 32'(pix_bus.pix_data), 32'(exp_p.data));
          check("pix_sof", 32'(pix_bus.pix_sof), 32'(exp_p.sof));
          check("pix_eol", 32'(pix_bus.pix_eol), 32'(exp_p.eol));
        end
        accepted++;
        if (pix_q.size() == 0) begin
          fin = 1'b1;
          if (restart_at == -2) start = 1'b1;
        end
      end
      held        = pix_bus.pix_valid && !pix_bus.pix_ready;
      held_p.data = pix_bus.pix_data;
      held_p.sof  = pix_bus.pix_sof;
      held_p.eol  = pix_bus.pix_eol;
      outstanding = outstanding + int'(bram_en) - int'(acc);
      if (abort_after > 0 && accepted == abort_after) return;
    end
    if (!fin) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check("done_set", 32'(frame_done), 32'd1);
      check("busy_fall", 32'(busy), 32'd0);
      check("idle_no_read", 32'(bram_en), 32'd0);
      check("addr_q_empty", 32'(addr_q.size()), 32'd0);
    end
  endtask

  initial begin
    bit stale;
    for (int i = 0; i < SRC_W*SRC_H; i++) mem[i] = 16'hA500 + 16'(i * 37);
    rst = 1'b1;
    start = 1'b0;
    scale_x = SCALE_X1;
    scale_y = SCALE_X1;
    pix_bus.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_valid", 32'(pix_bus.pix_valid), 32'd0);
    check("rst_data", 32'(pix_bus.pix_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    run_frame(SCALE_X1, SCALE_X1, 0, 0, -1);
    run_frame(SCALE_X2, SCALE_X2, 0, 0, -1);
    run_frame(SCALE_HALF, SCALE_HALF, 0, 0, -1);
    run_frame(SCALE_X4, SCALE_X1, 0, 0, -1);
    run_frame(SCALE_X1, SCALE_X1, 1, 0, -1);
    run_frame(SCALE_X1, SCALE_X1, 2, 0, -1);

    // Reset mid-frame after five accepted pixels.
    run_frame(SCALE_X1, SCALE_X1, 0, 5, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_valid", 32'(pix_bus.pix_valid), 32'd0);
    check("midrst_outs", 32'({bram_en, bram_addr, pix_bus.pix_sof, pix_bus.pix_eol, busy, frame_done}), 32'd0);
    check("midrst_data", 32'(pix_bus.pix_data), 32'd0);
    rst = 1'b0;
    addr_q.delete();
    pix_q.delete();
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pix_bus.pix_valid || busy) stale = 1'b1;
    end
    check("no_stale_data", 32'(stale), 32'd0);
    run_frame(SCALE_X1, SCALE_X1, 0, 0, -1);

    run_frame(SCALE_X1, SCALE_X1, 0, 0, 6);
    run_frame(SCALE_X1, SCALE_X1, 2, 0, -2);
    run_frame(SCALE_X2, SCALE_X1, 1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
